// File: rtl/dual_mode_stack_pkg.sv
// Shared constants and helpers for the dual-mode LIFO/FIFO buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package stack_pkg;

  // Values carried on the per-cycle mode select.
  localparam logic MODE_LIFO = 1'b0;
  localparam logic MODE_FIFO = 1'b1;

  // Occupancy needs one extra bit so that a completely full buffer is representable.
  function automatic int count_bits(input int address_bits);
    return address_bits + 1;
  endfunction

endpackage

// File: rtl/dual_mode_stack_if.sv
// Request/status bundle between a producer/consumer and the dual-mode buffer.
// Latency: n/a (wiring only).
// Backpressure: none in-band; the buffer reports full/empty and sticky error flags instead.
interface dual_mode_stack_if #(
  parameter int DATA_BITS    = 8,
  parameter int ADDRESS_BITS = 4
) ();

  localparam int CW = stack_pkg::count_bits(ADDRESS_BITS);

  logic                 push;
  logic                 pop;
  logic                 clear;
  logic                 mode;
  logic [DATA_BITS-1:0] w_data;
  logic [DATA_BITS-1:0] r_data;
  logic                 empty;
  logic                 full;
  logic                 almost_full;
  logic [CW-1:0]        count;
  logic                 overflow;
  logic                 underflow;

  modport master (
    output push, pop, clear, mode, w_data,
    input  r_data, empty, full, almost_full, count, overflow, underflow
  );

  modport slave (
    input  push, pop, clear, mode, w_data,
    output r_data, empty, full, almost_full, count, overflow, underflow
  );

endinterface

// File: rtl/dual_mode_stack_regfile.sv
// Storage array: one synchronous write port, one asynchronous read port, contents not reset.
// Latency: write visible on the read port the cycle after the write edge.
// Backpressure: none; every write strobe is accepted.
module stack_regfile #(
  parameter int DATA_BITS    = 8,
  parameter int ADDRESS_BITS = 4
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [ADDRESS_BITS-1:0] waddr,
  input  logic [DATA_BITS-1:0]    wdata,
  input  logic [ADDRESS_BITS-1:0] raddr,
  output logic [DATA_BITS-1:0]    rdata
);

  logic [DATA_BITS-1:0] mem [2**ADDRESS_BITS];

  // Write the addressed word on the rising edge when strobed.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dual_mode_stack.sv
// Register-file buffer acting as LIFO or FIFO per cycle, with count, almost-full, sticky errors, flush.
// Latency: a push at edge N is visible on the outputs after edge N and poppable at edge N+1.
// Backpressure: push when full is dropped (sets overflow); pop when empty is ignored (sets underflow).
module dual_mode_stack
  import stack_pkg::*;
#(
  parameter int DATA_BITS         = 8,
  parameter int ADDRESS_BITS      = 4,
  parameter int ALMOST_FULL_LEVEL = 2**ADDRESS_BITS - 2
) (
  input logic              clk,
  input logic              reset,
  dual_mode_stack_if.slave bus
);

  localparam int                      CW       = count_bits(ADDRESS_BITS);
  localparam logic [CW-1:0]           FULL_CNT = CW'(2**ADDRESS_BITS);
  localparam logic [CW-1:0]           AF_LVL   = CW'(ALMOST_FULL_LEVEL);
  localparam logic [CW-1:0]           ONE_C    = CW'(1);
  localparam logic [ADDRESS_BITS-1:0] ONE_A    = ADDRESS_BITS'(1);

  logic [ADDRESS_BITS-1:0] head_q, head_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    ovf_q, ovf_d;
  logic                    udf_q, udf_d;
  logic                    mode_q;
  logic [ADDRESS_BITS-1:0] tail, top, raddr, waddr;
  logic                    we;
  logic                    is_empty, is_full, fifo;
  logic [DATA_BITS-1:0]    rd_word;

  // Indices wrap naturally at the array size.
  assign tail     = head_q + count_q[ADDRESS_BITS-1:0];
  assign top      = tail - ONE_A;
  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == FULL_CNT);
  assign fifo     = (bus.mode == MODE_FIFO);

  // Next-state: flush wins, then push+pop on a non-empty buffer, then single push or pop.
  always_comb begin
    head_d  = head_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    we      = 1'b0;
    waddr   = tail;
    if (bus.clear) begin
      head_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
    end else if (bus.push && bus.pop && !is_empty) begin
      // Occupancy is unchanged: LIFO replaces the top, FIFO writes the tail as the head leaves.
      we = 1'b1;
      if (fifo) begin
        waddr  = tail;
        head_d = head_q + ONE_A;
      end else begin
        waddr = top;
      end
    end else if (bus.push) begin
      // Also covers push+pop on an empty buffer, which behaves as a plain push.
      if (is_full) begin
        ovf_d = 1'b1;
      end else begin
        we      = 1'b1;
        count_d = count_q + ONE_C;
      end
    end else if (bus.pop) begin
      if (is_empty) begin
        udf_d = 1'b1;
      end else begin
        count_d = count_q - ONE_C;
        if (fifo) begin
          head_d = head_q + ONE_A;
        end
      end
    end
  end

  // Pointer, occupancy, error and view registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      mode_q  <= MODE_LIFO;
    end else begin
      head_q  <= head_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
      mode_q  <= bus.mode;
    end
  end

  stack_regfile #(
    .DATA_BITS   (DATA_BITS),
    .ADDRESS_BITS(ADDRESS_BITS)
  ) u_regfile (
    .clk  (clk),
    .we   (we),
    .waddr(waddr),
    .wdata(bus.w_data),
    .raddr(raddr),
    .rdata(rd_word)
  );

  // The output view follows the mode seen at the last edge so r_data has no path from inputs.
  assign raddr           = (mode_q == MODE_FIFO) ? head_q : top;
  assign bus.r_data      = is_empty ? '0 : rd_word;
  assign bus.empty       = is_empty;
  assign bus.full        = is_full;
  assign bus.almost_full = (count_q >= AF_LVL);
  assign bus.count       = count_q;
  assign bus.overflow    = ovf_q;
  assign bus.underflow   = udf_q;

endmodule

// File: tb/tb_dual_mode_stack.sv
module tb_dual_mode_stack;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  dual_mode_stack_if #(.DATA_BITS(8), .ADDRESS_BITS(2)) bus ();

  dual_mode_stack #(
    .DATA_BITS        (8),
    .ADDRESS_BITS     (2),
    .ALMOST_FULL_LEVEL(3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flag vector layout: {empty, full, almost_full, overflow, underflow}
  localparam logic [4:0] FE = 5'b10000;
  localparam logic [4:0] FF = 5'b01000;
  localparam logic [4:0] FA = 5'b00100;
  localparam logic [4:0] FO = 5'b00010;
  localparam logic [4:0] FU = 5'b00001;
  localparam logic [4:0] FN = 5'b00000;

  typedef struct {
    logic       push;
    logic       pop;
    logic       clr;
    logic       mode;
    logic [7:0] wd;
    logic [7:0] er;
    logic [2:0] ec;
    logic [4:0] ef;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t v(input logic pu, input logic po, input logic cl, input logic md,
                             input logic [7:0] wd, input logic [7:0] er, input logic [2:0] ec,
                             input logic [4:0] ef);
    vec_t r;
    r.push = pu; r.pop = po; r.clr = cl; r.mode = md;
    r.wd = wd; r.er = er; r.ec = ec; r.ef = ef;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask

  function automatic logic [4:0] flags();
    return {bus.empty, bus.full, bus.almost_full, bus.overflow, bus.underflow};
  endfunction

  task automatic drive(input logic pu, input logic po, input logic cl, input logic md,
                       input logic [7:0] wd);
    bus.push = pu; bus.pop = po; bus.clear = cl; bus.mode = md; bus.w_data = wd;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

    // LIFO order
    vt.push_back(v(1,0,0,0,8'h11, 8'h11, 3'd1, FN));
    vt.push_back(v(1,0,0,0,8'h22, 8'h22, 3'd2, FN));
    vt.push_back(v(1,0,0,0,8'h33, 8'h33, 3'd3, FA));
    vt.push_back(v(0,1,0,0,8'h00, 8'h22, 3'd2, FN));
    vt.push_back(v(0,1,0,0,8'h00, 8'h11, 3'd1, FN));
    vt.push_back(v(0,1,0,0,8'h00, 8'h00, 3'd0, FE));
    // FIFO with head wrap
    vt.push_back(v(1,0,0,1,8'hA0, 8'hA0, 3'd1, FN));
    vt.push_back(v(1,0,0,1,8'hA1, 8'hA0, 3'd2, FN));
    vt.push_back(v(1,0,0,1,8'hA2, 8'hA0, 3'd3, FA));
    vt.push_back(v(1,0,0,1,8'hA3, 8'hA0, 3'd4, FF|FA));
    vt.push_back(v(0,1,0,1,8'h00, 8'hA1, 3'd3, FA));
    vt.push_back(v(0,1,0,1,8'h00, 8'hA2, 3'd2, FN));
    vt.push_back(v(1,0,0,1,8'hB0, 8'hA2, 3'd3, FA));
    vt.push_back(v(1,0,0,1,8'hB1, 8'hA2, 3'd4, FF|FA));
    vt.push_back(v(0,1,0,1,8'h00, 8'hA3, 3'd3, FA));
    vt.push_back(v(0,1,0,1,8'h00, 8'hB0, 3'd2, FN));
    vt.push_back(v(0,1,0,1,8'h00, 8'hB1, 3'd1, FN));
    vt.push_back(v(0,1,0,1,8'h00, 8'h00, 3'd0, FE));
    // Overflow, underflow, clear (clear beats same-cycle push+pop)
    vt.push_back(v(1,0,0,1,8'h01, 8'h01, 3'd1, FN));
    vt.push_back(v(1,0,0,1,8'h02, 8'h01, 3'd2, FN));
    vt.push_back(v(1,0,0,1,8'h03, 8'h01, 3'd3, FA));
    vt.push_back(v(1,0,0,1,8'h04, 8'h01, 3'd4, FF|FA));
    vt.push_back(v(1,0,0,1,8'h05, 8'h01, 3'd4, FF|FA|FO));
    vt.push_back(v(0,1,0,1,8'h00, 8'h02, 3'd3, FA|FO));
    vt.push_back(v(0,1,0,1,8'h00, 8'h03, 3'd2, FO));
    vt.push_back(v(0,1,0,1,8'h00, 8'h04, 3'd1, FO));
    vt.push_back(v(0,1,0,1,8'h00, 8'h00, 3'd0, FE|FO));
    vt.push_back(v(0,1,0,1,8'h00, 8'h00, 3'd0, FE|FO|FU));
    vt.push_back(v(1,1,1,1,8'hEE, 8'h00, 3'd0, FE));
    // Simultaneous push+pop: LIFO full, then FIFO full, then empty
    vt.push_back(v(1,0,0,0,8'h01, 8'h01, 3'd1, FN));
    vt.push_back(v(1,0,0,0,8'h02, 8'h02, 3'd2, FN));
    vt.push_back(v(1,0,0,0,8'h03, 8'h03, 3'd3, FA));
    vt.push_back(v(1,0,0,0,8'h04, 8'h04, 3'd4, FF|FA));
    vt.push_back(v(1,1,0,0,8'h55, 8'h55, 3'd4, FF|FA));
    vt.push_back(v(1,1,0,1,8'h66, 8'h02, 3'd4, FF|FA));
    vt.push_back(v(0,1,0,1,8'h00, 8'h03, 3'd3, FA));
    vt.push_back(v(0,1,0,1,8'h00, 8'h55, 3'd2, FN));
    vt.push_back(v(0,1,0,1,8'h00, 8'h66, 3'd1, FN));
    vt.push_back(v(0,1,0,1,8'h00, 8'h00, 3'd0, FE));
    vt.push_back(v(1,1,0,1,8'h77, 8'h77, 3'd1, FN));
    vt.push_back(v(0,1,0,1,8'h00, 8'h00, 3'd0, FE));
    // Mode switch on a non-empty buffer
    vt.push_back(v(1,0,0,0,8'h01, 8'h01, 3'd1, FN));
    vt.push_back(v(1,0,0,0,8'h02, 8'h02, 3'd2, FN));
    vt.push_back(v(1,0,0,0,8'h03, 8'h03, 3'd3, FA));
    vt.push_back(v(0,0,0,1,8'h00, 8'h01, 3'd3, FA));
    vt.push_back(v(0,1,0,1,8'h00, 8'h02, 3'd2, FN));

    // Reset state, checked while reset is held and before any clock edge
    #2;
    chk("reset r_data", 32'(bus.r_data), 32'h0);
    chk("reset count",  32'(bus.count),  32'h0);
    chk("reset flags",  32'(flags()),    32'(FE));
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].push, vt[i].pop, vt[i].clr, vt[i].mode, vt[i].wd);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d r_data", i), 32'(bus.r_data), 32'(vt[i].er));
      chk($sformatf("vec%0d count", i),  32'(bus.count),  32'(vt[i].ec));
      chk($sformatf("vec%0d flags", i),  32'(flags()),    32'(vt[i].ef));
    end

    // Fill to full (two more words) and overflow once, in LIFO
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'hC0 + k));
      @(posedge clk);
      #1;
    end
    chk("pre-reset count", 32'(bus.count), 32'd4);
    chk("pre-reset flags", 32'(flags()),   32'(FF|FA|FO));
    chk("pre-reset r_data", 32'(bus.r_data), 32'hC1);

    // Asynchronous reset between edges with requests still asserted
    #3;
    reset = 1'b1;
    #1;
    chk("async reset r_data", 32'(bus.r_data), 32'h0);
    chk("async reset count",  32'(bus.count),  32'h0);
    chk("async reset flags",  32'(flags()),    32'(FE));
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    reset = 1'b0;

    // First edge after release sees an empty buffer: a pop underflows
    drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    @(posedge clk);
    #1;
    chk("post-reset pop count", 32'(bus.count), 32'h0);
    chk("post-reset pop flags", 32'(flags()),   32'(FE|FU));
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
